// File: rtl/multicycle_ctr_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// The controller is the master: it drives every enable and mux select and receives opCode and mem_ready.
interface multicycle_ctr_if;
  logic [5:0] opCode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opCode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
           state, instr_done, illegal_op
  );

  modport slave (
    output opCode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
           state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_ctr.sv
// Multi-cycle main control FSM for the MIPS datapath: fetch, decode, execute, memory and writeback.
// Outputs are a combinational decode of the state register, with memory wait states driven by mem_ready.
module multicycle_ctr #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic           clk,
  input  logic           reset,
  multicycle_ctr_if.master ctrl
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  state_t     curState, nextState;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memtoReg, irWrite;
  logic [1:0] pcSource, aluOp, aluSrcB;
  logic       aluSrcA, regWrite, regDst, instrDone, illegalOp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) curState <= FETCH;
    else       curState <= nextState;
  end

  // Outputs are gated by reset so that FETCH's memory read never leaks out while reset is held.
  always_comb begin
    nextState   = FETCH;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memtoReg    = 1'b0;
    irWrite     = 1'b0;
    pcSource    = 2'b00;
    aluOp       = 2'b00;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    instrDone   = 1'b0;
    illegalOp   = 1'b0;
    if (!reset) begin
      case (curState)
        FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = ctrl.mem_ready;
          pcWrite = ctrl.mem_ready;
          if (ctrl.mem_ready) nextState = DECODE;
          else                nextState = FETCH;
        end
        DECODE: begin
          aluSrcB = 2'b11;
          case (ctrl.opCode)
            OP_LW, OP_SW: nextState = MEM_ADDR;
            OP_RTYPE:     nextState = EXECUTE;
            OP_BEQ:       nextState = BRANCH;
            OP_J:         nextState = JUMP;
            OP_ADDI:      nextState = ADDI_EXEC;
            default: begin
              nextState = FETCH;
              illegalOp = 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          if (ctrl.opCode == OP_LW)      nextState = MEM_READ;
          else if (ctrl.opCode == OP_SW) nextState = MEM_WRITE;
          else                           nextState = FETCH;
        end
        MEM_READ: begin
          memRead = 1'b1;
          iorD    = 1'b1;
          if (ctrl.mem_ready) nextState = MEM_WB;
          else                nextState = MEM_READ;
        end
        MEM_WB: begin
          memtoReg  = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        MEM_WRITE: begin
          memWrite  = 1'b1;
          iorD      = 1'b1;
          instrDone = ctrl.mem_ready;
          if (ctrl.mem_ready) nextState = FETCH;
          else                nextState = MEM_WRITE;
        end
        EXECUTE: begin
          aluSrcA   = 1'b1;
          aluOp     = 2'b10;
          nextState = R_WB;
        end
        R_WB: begin
          regDst    = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        BRANCH: begin
          aluSrcA     = 1'b1;
          aluOp       = 2'b01;
          pcWriteCond = 1'b1;
          pcSource    = 2'b01;
          instrDone   = 1'b1;
        end
        JUMP: begin
          pcWrite   = 1'b1;
          pcSource  = 2'b10;
          instrDone = 1'b1;
        end
        ADDI_EXEC: begin
          aluSrcA   = 1'b1;
          aluSrcB   = 2'b10;
          nextState = ADDI_WB;
        end
        ADDI_WB: begin
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        default: nextState = FETCH;
      endcase
    end
  end

  assign ctrl.PCWrite     = pcWrite;
  assign ctrl.PCWriteCond = pcWriteCond;
  assign ctrl.IorD        = iorD;
  assign ctrl.MemRead     = memRead;
  assign ctrl.MemWrite    = memWrite;
  assign ctrl.MemtoReg    = memtoReg;
  assign ctrl.IRWrite     = irWrite;
  assign ctrl.PCSource    = pcSource;
  assign ctrl.ALUOp       = aluOp;
  assign ctrl.ALUSrcA     = aluSrcA;
  assign ctrl.ALUSrcB     = aluSrcB;
  assign ctrl.RegWrite    = regWrite;
  assign ctrl.RegDst      = regDst;
  assign ctrl.state       = curState;
  assign ctrl.instr_done  = instrDone;
  assign ctrl.illegal_op  = illegalOp;

endmodule

// File: tb/tb_multicycle_ctr.sv
// Self-checking bench for multicycle_ctr: a per-cycle table of directed vectors
// followed by a hand-written async-reset-during-store sequence.
module tb_multicycle_ctr;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] outs;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  multicycle_ctr_if bus();

  multicycle_ctr dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  logic [17:0] actOut;
  assign actOut = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                   bus.MemtoReg, bus.IRWrite, bus.PCSource, bus.ALUOp, bus.ALUSrcA,
                   bus.ALUSrcB, bus.RegWrite, bus.RegDst, bus.instr_done, bus.illegal_op};

  // Field order matches actOut so expected constants read like the per-state output list.
  function automatic logic [17:0] mk(
    input logic pcw, input logic pcwc, input logic iord, input logic mrd, input logic mwr,
    input logic m2r, input logic irw, input logic [1:0] pcs, input logic [1:0] aop,
    input logic asa, input logic [1:0] asb, input logic rw, input logic rd,
    input logic done, input logic ill);
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, done, ill};
  endfunction

  logic [17:0] oZero, oFetchRdy, oFetchWait, oDecode, oDecodeIll, oMemAddr, oMemRead, oMemWb;
  logic [17:0] oMemWrWait, oMemWrRdy, oExec, oRWb, oBranch, oJump, oAddiExec, oAddiWb;

  task automatic checkOutput(input string tag, input int idx, input logic [3:0] expSt,
                             input logic [17:0] expOut);
    total++;
    if (bus.state !== expSt) begin
      bad++;
      $display("[TB] FAIL %s[%0d] state: got %0d want %0d", tag, idx, bus.state, expSt);
    end
    total++;
    if (actOut !== expOut) begin
      bad++;
      $display("[TB] FAIL %s[%0d] outputs: got %b want %b", tag, idx, actOut, expOut);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic mr);
    @(negedge clk);
    bus.opCode    = op;
    bus.mem_ready = mr;
    #2;
  endtask

  function automatic void addVec(input logic [5:0] op, input logic mr, input logic [3:0] st,
                                 input logic [17:0] outs);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.outs = outs;
    vecs.push_back(v);
  endfunction

  initial begin
    oZero      = '0;
    oFetchRdy  = mk(1,0,0,1,0,0,1,2'b00,2'b00,0,2'b01,0,0,0,0);
    oFetchWait = mk(0,0,0,1,0,0,0,2'b00,2'b00,0,2'b01,0,0,0,0);
    oDecode    = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0,0,0);
    oDecodeIll = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0,0,1);
    oMemAddr   = mk(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0);
    oMemRead   = mk(0,0,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,0);
    oMemWb     = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,2'b00,1,0,1,0);
    oMemWrWait = mk(0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0,0,0);
    oMemWrRdy  = mk(0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0,1,0);
    oExec      = mk(0,0,0,0,0,0,0,2'b00,2'b10,1,2'b00,0,0,0,0);
    oRWb       = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,1,1,0);
    oBranch    = mk(0,1,0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0,1,0);
    oJump      = mk(1,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,0,0,1,0);
    oAddiExec  = mk(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0);
    oAddiWb    = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0,1,0);

    // lw, no waits
    addVec(LW,1,0,oFetchRdy);  addVec(LW,1,1,oDecode);   addVec(LW,1,2,oMemAddr);
    addVec(LW,1,3,oMemRead);   addVec(LW,1,4,oMemWb);
    // R-type with mem_ready low where it must be ignored
    addVec(RT,1,0,oFetchRdy);  addVec(RT,0,1,oDecode);   addVec(RT,0,6,oExec);
    addVec(RT,0,7,oRWb);
    addVec(BEQ,1,0,oFetchRdy); addVec(BEQ,0,1,oDecode);  addVec(BEQ,0,8,oBranch);
    addVec(JMP,1,0,oFetchRdy); addVec(JMP,1,1,oDecode);  addVec(JMP,1,9,oJump);
    addVec(ADDI,1,0,oFetchRdy); addVec(ADDI,1,1,oDecode); addVec(ADDI,0,10,oAddiExec);
    addVec(ADDI,1,11,oAddiWb);
    // fetch stalled three cycles
    addVec(RT,0,0,oFetchWait); addVec(RT,0,0,oFetchWait); addVec(RT,0,0,oFetchWait);
    addVec(RT,1,0,oFetchRdy);  addVec(RT,1,1,oDecode);   addVec(RT,1,6,oExec);
    addVec(RT,1,7,oRWb);
    // lw with two read wait states
    addVec(LW,1,0,oFetchRdy);  addVec(LW,1,1,oDecode);   addVec(LW,1,2,oMemAddr);
    addVec(LW,0,3,oMemRead);   addVec(LW,0,3,oMemRead);  addVec(LW,1,3,oMemRead);
    addVec(LW,0,4,oMemWb);
    // sw with one write wait state
    addVec(SW,1,0,oFetchRdy);  addVec(SW,1,1,oDecode);   addVec(SW,1,2,oMemAddr);
    addVec(SW,0,5,oMemWrWait); addVec(SW,1,5,oMemWrRdy);
    // unsupported opcodes
    addVec(6'b111111,1,0,oFetchRdy); addVec(6'b111111,1,1,oDecodeIll);
    addVec(6'b000011,1,0,oFetchRdy); addVec(6'b000011,1,1,oDecodeIll);
    addVec(RT,0,0,oFetchWait);

    reset         = 1'b1;
    bus.opCode    = LW;
    bus.mem_ready = 1'b1;
    #3;
    checkOutput("reset", 0, 4'd0, oZero);
    @(posedge clk); #1;
    checkOutput("reset", 1, 4'd0, oZero);

    @(negedge clk);
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    checkOutput("release", 0, 4'd0, oFetchWait);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].mr);
      checkOutput("vec", i, vecs[i].st, vecs[i].outs);
    end

    // Reset asserted mid-cycle while a store is stalled in MEM_WRITE.
    applyStimulus(SW, 1'b1); checkOutput("swrst", 0, 4'd0, oFetchRdy);
    applyStimulus(SW, 1'b1); checkOutput("swrst", 1, 4'd1, oDecode);
    applyStimulus(SW, 1'b1); checkOutput("swrst", 2, 4'd2, oMemAddr);
    applyStimulus(SW, 1'b0); checkOutput("swrst", 3, 4'd5, oMemWrWait);
    applyStimulus(SW, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("swrst", 4, 4'd0, oZero);
    bus.mem_ready = 1'b1;
    #1;
    checkOutput("swrst", 5, 4'd0, oZero);
    @(posedge clk); #1;
    checkOutput("swrst", 6, 4'd0, oZero);
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    checkOutput("swrst", 7, 4'd0, oFetchWait);
    applyStimulus(RT, 1'b1); checkOutput("swrst", 8, 4'd0, oFetchRdy);
    applyStimulus(RT, 1'b1); checkOutput("swrst", 9, 4'd1, oDecode);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
